mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM outputs, runs loads and stores over a request/acknowledge data bus, and does byte/half alignment with sign or zero extension.
- Selects the write-back value and registers it into the MEM/WB boundary.
- Drives mem_stall so upstream stages freeze while a bus access is outstanding.

Parameters:
- ADDR_W, 32, data-bus address width; the address is taken from mem_C[ADDR_W-1:0].
- WSEL_LOAD, 2'b01, value of mem_s_rf_wsel that marks a load.

Ports:
- cpu_clk  in  1  stage clock
- cpu_rst_n  in  1  asynchronous active-low reset
- mem_pc4  in  32  PC+4 of the instruction
- mem_inst  in  32  instruction word; [14:12]=funct3, [11:7]=rd
- mem_rD2  in  32  store source data
- mem_ext  in  32  immediate (write-back source)
- mem_s_rf_wsel  in  2  write-back select: 00=C, 01=load data, 10=pc4, 11=ext
- mem_rf_we  in  1  register-file write enable
- mem_ram_we  in  1  store request
- mem_C  in  32  ALU result / effective address
- valid_in  in  1  instruction valid
- dbus_req  out  1  bus request
- dbus_we  out  1  1=write
- dbus_addr  out  ADDR_W  word-aligned address
- dbus_wdata  out  32  replicated store data
- dbus_wstrb  out  4  byte enables
- dbus_ack  in  1  bus acknowledge (one cycle)
- dbus_rdata  in  32  read data, valid with dbus_ack
- mem_stall  out  1  freeze upstream stages
- wb_wd  out  32  registered write-back data
- wb_wR  out  5  registered destination register
- wb_rf_we  out  1  registered write enable
- wb_inst  out  32  registered instruction
- valid_out  out  1  registered valid

Behaviour:
- Reset is asynchronous and active-low: cpu_rst_n=0 clears the FSM to IDLE and sets wb_wd, wb_wR, wb_rf_we, wb_inst and valid_out to 0. dbus_req and mem_stall are 0 while cpu_rst_n=0.
- Memory op: memop = valid_in & (mem_ram_we | mem_s_rf_wsel==WSEL_LOAD).
- FSM states: IDLE and BUSY.
  - dbus_req = (IDLE & memop) | BUSY.
  - IDLE to BUSY when dbus_req & !dbus_ack.
  - BUSY to IDLE on dbus_ack.
  - A zero-wait ack (ack in the same cycle as the request) completes in IDLE in one cycle.
- mem_stall = dbus_req & !dbus_ack (combinational).
- Upstream must hold all mem_* inputs and valid_in stable while mem_stall=1, so the dbus_* outputs stay stable for the whole request.
- Address and write data:
  - dbus_addr = {mem_C[ADDR_W-1:2], 2'b00}.
  - dbus_we = mem_ram_we.
  - funct3 000 (SB): wdata = {4{rD2[7:0]}}, wstrb = 4'b0001 << C[1:0].
  - funct3 001 (SH): wdata = {2{rD2[15:0]}}, wstrb = 4'b0011 << {C[1],1'b0}.
  - Otherwise (SW): wdata = rD2, wstrb = 4'b1111.
  - Loads drive wstrb = 4'b0000.
- Load extraction from dbus_rdata uses the lane given by C[1:0]:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 010 and any undefined funct3: full word.
- Write-back mux selects per mem_s_rf_wsel.
- MEM/WB register, one cycle latency:
  - Each cycle where the instruction completes (memop & ack, or !memop): wb_wd, wb_wR = mem_inst[11:7], wb_rf_we = mem_rf_we & valid_in, wb_inst and valid_out = valid_in.
  - While mem_stall=1: valid_out <= 0 and wb_rf_we <= 0 (a bubble is inserted); the other wb_* fields hold.
- An ack while dbus_req=0 is ignored.
- Reset during BUSY abandons the access. A late ack after reset is ignored.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: a halfword access with C[0]=1, or a word access with C[1:0]!=0, is misaligned.
  - No bus request is issued and there is no stall.
  - Extra output wb_misalign (1 bit, reset 0) is registered high with valid_out.
  - wb_rf_we is forced to 0 for that instruction.
- Undefined: no wb_misalign port. Low address bits are ignored for word accesses, and the halfword lane uses C[1] only.

Decomposition:
- Shared package holds: write-back select encodings (WSEL_C, WSEL_LOAD, WSEL_PC4, WSEL_EXT), funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and FSM state encodings.
- One sub-module, mem_align: purely combinational store lane/strobe generation and load extract/extend. The FSM and MEM/WB register stay in mem_stage.

Test Plan:
- SW: C=0x1004, rD2=0xDEADBEEF, ack on 3rd cycle → addr=0x1004, wstrb=1111, mem_stall high for 2 cycles, then valid_out=1 with wb_rf_we=0.
- LB: C=0x2003, rdata=0x80AA55CC, zero-wait ack → wb_wd=0xFFFFFF80 next cycle, no stall cycle.
- LHU: C=0x2002, rdata=0x80AA55CC → wb_wd=0x000080AA. SB: C=0x3001, rD2=0x12 → wdata=0x12121212, wstrb=0010.
- ALU op: wsel=00, C=0x55 → no dbus_req, wb_wd=0x55 next cycle. wsel=10 → wb_wd=mem_pc4.
- Reset: cpu_rst_n low during BUSY → dbus_req=0 immediately, all wb_* =0. Ack pulse after release → no write-back.
- With MEM_MISALIGN_TRAP_EN: LW with C=0x1002 → no dbus_req, wb_misalign=1, wb_rf_we=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the memory-access stage.
//   - write-back select values (mem_s_rf_wsel)
//   - funct3 access-size values for loads and stores
//   - FSM state encodings for the bus handshake
package mem_stage_pkg;

   // Write-back source select
   localparam logic [1:0] WSEL_C    = 2'b00;
   localparam logic [1:0] WSEL_LOAD = 2'b01;
   localparam logic [1:0] WSEL_PC4  = 2'b10;
   localparam logic [1:0] WSEL_EXT  = 2'b11;

   // funct3 access sizes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Bus FSM states
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational store lane/strobe generation and load extract/extend.
// Ports:
//   i_funct3   access size/signedness from the instruction
//   i_addr_lo  low two bits of the effective address (byte lane)
//   i_rd2      store source data
//   i_rdata    bus read data
//   o_wdata    store data replicated across lanes
//   o_wstrb    store byte enables (caller masks for loads)
//   o_load     aligned, extended load result
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_rd2,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_load
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Store side: replicate data so the strobe alone picks the lane
   always_comb begin
      o_wdata = i_rd2;
      o_wstrb = 4'b1111;
      case (i_funct3)
         F3_B: begin
            o_wdata = {4{i_rd2[7:0]}};
            o_wstrb = 4'b0001 << i_addr_lo;
         end
         F3_H: begin
            o_wdata = {2{i_rd2[15:0]}};
            o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
         end
         default: ;
      endcase
   end

   // Load side: halfword lane uses addr bit 1 only
   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
         default: ;
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

      o_load = i_rdata;
      case (i_funct3)
         F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_load = {{16{w_half[15]}}, w_half};
         F3_BU:   o_load = {24'b0, w_byte};
         F3_HU:   o_load = {16'b0, w_half};
         default: o_load = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX/MEM and MEM/WB.
// Runs loads/stores over a req/ack data bus, aligns load data, selects the
// write-back value and registers it. mem_stall freezes upstream while a bus
// access is outstanding.
// Ports:
//   cpu_clk, cpu_rst_n      clock, async active-low reset
//   mem_*, valid_in         EX/MEM outputs
//   dbus_*                  data bus (dbus_ack/dbus_rdata in, rest out)
//   mem_stall               upstream freeze
//   wb_*, valid_out         registered MEM/WB outputs
// Optional: MEM_MISALIGN_TRAP_EN adds wb_misalign and suppresses misaligned
// halfword/word accesses.
module mem_stage #(
   parameter int unsigned ADDR_W    = 32,
   parameter logic [1:0]  WSEL_LOAD = mem_stage_pkg::WSEL_LOAD
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst_n,
   input  logic [31:0]       mem_pc4,
   input  logic [31:0]       mem_inst,
   input  logic [31:0]       mem_rD2,
   input  logic [31:0]       mem_ext,
   input  logic [1:0]        mem_s_rf_wsel,
   input  logic              mem_rf_we,
   input  logic              mem_ram_we,
   input  logic [31:0]       mem_C,
   input  logic              valid_in,
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [ADDR_W-1:0] dbus_addr,
   output logic [31:0]       dbus_wdata,
   output logic [3:0]        dbus_wstrb,
   input  logic              dbus_ack,
   input  logic [31:0]       dbus_rdata,
   output logic              mem_stall,
   output logic [31:0]       wb_wd,
   output logic [4:0]        wb_wR,
   output logic              wb_rf_we,
   output logic [31:0]       wb_inst,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic              wb_misalign,
`endif
   output logic              valid_out
);

   import mem_stage_pkg::*;

   logic [0:0]  r_state;
   logic [0:0]  w_state_nxt;
   logic        w_memop;
   logic        w_misalign;
   logic        w_req;
   logic        w_stall;
   logic [2:0]  w_funct3;
   logic [31:0] w_wdata;
   logic [3:0]  w_wstrb;
   logic [31:0] w_load;
   logic [31:0] w_wd;

   logic [31:0] r_wd;
   logic [4:0]  r_wR;
   logic        r_rf_we;
   logic [31:0] r_inst;
   logic        r_valid;
   logic        r_misalign;

   assign w_funct3 = mem_inst[14:12];
   assign w_memop  = valid_in & (mem_ram_we | (mem_s_rf_wsel == WSEL_LOAD));

`ifdef MEM_MISALIGN_TRAP_EN
   logic w_is_byte;
   logic w_is_half;
   // Store decoding treats every non-B/H funct3 as a word; loads also have BU/HU
   always_comb begin
      w_is_byte  = (w_funct3 == F3_B) | (!mem_ram_we & (w_funct3 == F3_BU));
      w_is_half  = (w_funct3 == F3_H) | (!mem_ram_we & (w_funct3 == F3_HU));
      w_misalign = w_memop & ((w_is_half & mem_C[0]) |
                              (!w_is_byte & !w_is_half & (mem_C[1:0] != 2'b00)));
   end
`else
   assign w_misalign = 1'b0;
`endif

   // Reset gates the request so nothing leaks onto the bus while held in reset
   assign w_req     = cpu_rst_n & (((r_state == ST_IDLE) & w_memop & !w_misalign) |
                                   (r_state == ST_BUSY));
   assign w_stall   = w_req & !dbus_ack;
   assign dbus_req  = w_req;
   assign mem_stall = w_stall;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_req && !dbus_ack) w_state_nxt = ST_BUSY;
         ST_BUSY: if (dbus_ack)           w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

   mem_align u_align (
      .i_funct3  (w_funct3),
      .i_addr_lo (mem_C[1:0]),
      .i_rd2     (mem_rD2),
      .i_rdata   (dbus_rdata),
      .o_wdata   (w_wdata),
      .o_wstrb   (w_wstrb),
      .o_load    (w_load)
   );

   assign dbus_we    = mem_ram_we;
   assign dbus_addr  = {mem_C[ADDR_W-1:2], 2'b00};
   assign dbus_wdata = w_wdata;
   assign dbus_wstrb = mem_ram_we ? w_wstrb : 4'b0000;

   // Load select is checked first so a non-default WSEL_LOAD still wins
   always_comb begin
      w_wd = mem_C;
      if (mem_s_rf_wsel == WSEL_LOAD) begin
         w_wd = w_load;
      end else begin
         case (mem_s_rf_wsel)
            WSEL_PC4: w_wd = mem_pc4;
            WSEL_EXT: w_wd = mem_ext;
            default:  w_wd = mem_C;
         endcase
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         r_wd       <= 32'b0;
         r_wR       <= 5'b0;
         r_rf_we    <= 1'b0;
         r_inst     <= 32'b0;
         r_valid    <= 1'b0;
         r_misalign <= 1'b0;
      end else if (w_stall) begin
         // Bubble: data fields hold, only the qualifiers drop
         r_rf_we    <= 1'b0;
         r_valid    <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_wd       <= w_wd;
         r_wR       <= mem_inst[11:7];
         r_rf_we    <= mem_rf_we & valid_in & !w_misalign;
         r_inst     <= mem_inst;
         r_valid    <= valid_in;
         r_misalign <= w_misalign;
      end
   end

   assign wb_wd     = r_wd;
   assign wb_wR     = r_wR;
   assign wb_rf_we  = r_rf_we;
   assign wb_inst   = r_inst;
   assign valid_out = r_valid;
`ifdef MEM_MISALIGN_TRAP_EN
   assign wb_misalign = r_misalign;
`else
   logic w_unused;
   assign w_unused = r_misalign;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed-vector bench for mem_stage.
// Set MEM_MISALIGN_TRAP_EN to also exercise the misalignment trap.
module tb_mem_stage;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst_n;
   logic [31:0] mem_pc4, mem_inst, mem_rD2, mem_ext, mem_C;
   logic [1:0]  mem_s_rf_wsel;
   logic        mem_rf_we, mem_ram_we, valid_in;
   logic        dbus_req, dbus_we, dbus_ack;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
   logic [3:0]  dbus_wstrb;
   logic        mem_stall;
   logic [31:0] wb_wd, wb_inst;
   logic [4:0]  wb_wR;
   logic        wb_rf_we, valid_out;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        wb_misalign;
`endif

   int n_vec = 0;
   int n_err = 0;

   mem_stage dut (
      .cpu_clk       (cpu_clk),
      .cpu_rst_n     (cpu_rst_n),
      .mem_pc4       (mem_pc4),
      .mem_inst      (mem_inst),
      .mem_rD2       (mem_rD2),
      .mem_ext       (mem_ext),
      .mem_s_rf_wsel (mem_s_rf_wsel),
      .mem_rf_we     (mem_rf_we),
      .mem_ram_we    (mem_ram_we),
      .mem_C         (mem_C),
      .valid_in      (valid_in),
      .dbus_req      (dbus_req),
      .dbus_we       (dbus_we),
      .dbus_addr     (dbus_addr),
      .dbus_wdata    (dbus_wdata),
      .dbus_wstrb    (dbus_wstrb),
      .dbus_ack      (dbus_ack),
      .dbus_rdata    (dbus_rdata),
      .mem_stall     (mem_stall),
      .wb_wd         (wb_wd),
      .wb_wR         (wb_wR),
      .wb_rf_we      (wb_rf_we),
      .wb_inst       (wb_inst),
`ifdef MEM_MISALIGN_TRAP_EN
      .wb_misalign   (wb_misalign),
`endif
      .valid_out     (valid_out)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic ram_we, input logic rf_we,
                        input logic [1:0] wsel, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] c, input logic [31:0] rd2);
      valid_in      = v;
      mem_ram_we    = ram_we;
      mem_rf_we     = rf_we;
      mem_s_rf_wsel = wsel;
      mem_inst      = {17'b0, f3, rd, ram_we ? 7'b0100011 : 7'b0000011};
      mem_C         = c;
      mem_rD2       = rd2;
   endtask

   initial begin
      cpu_rst_n  = 1'b0;
      mem_pc4    = 32'h0000_0104;
      mem_ext    = 32'h0000_CAFE;
      dbus_ack   = 1'b0;
      dbus_rdata = 32'h0;
      // A load is presented while in reset: the bus must stay quiet
      drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 5'd1, 32'h1000, 32'h0);
      #2;
      check("rst_req",   {31'b0, dbus_req},  32'h0);
      check("rst_stall", {31'b0, mem_stall}, 32'h0);
      check("rst_wd",    wb_wd,              32'h0);
      check("rst_wR",    {27'b0, wb_wR},     32'h0);
      check("rst_rfwe",  {31'b0, wb_rf_we},  32'h0);
      check("rst_inst",  wb_inst,            32'h0);
      check("rst_valid", {31'b0, valid_out}, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
      #10 cpu_rst_n = 1'b1;
      step();

      // ALU result write-back
      drive(1'b1, 1'b0, 1'b1, 2'b00, 3'b000, 5'd3, 32'h55, 32'h0);
      #1 check("alu_req", {31'b0, dbus_req}, 32'h0);
      step();
      check("alu_wd",   wb_wd,              32'h55);
      check("alu_wR",   {27'b0, wb_wR},     32'd3);
      check("alu_rfwe", {31'b0, wb_rf_we},  32'h1);
      check("alu_vld",  {31'b0, valid_out}, 32'h1);

      // PC+4 and immediate write-back
      mem_s_rf_wsel = 2'b10;
      step();
      check("pc4_wd", wb_wd, 32'h104);
      mem_s_rf_wsel = 2'b11;
      step();
      check("ext_wd", wb_wd, 32'hCAFE);

      // SW with ack in the third request cycle
      drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b010, 5'd5, 32'h1004, 32'hDEADBEEF);
      #1;
      check("sw_req",   {31'b0, dbus_req},  32'h1);
      check("sw_we",    {31'b0, dbus_we},   32'h1);
      check("sw_addr",  dbus_addr,          32'h1004);
      check("sw_wdata", dbus_wdata,         32'hDEADBEEF);
      check("sw_wstrb", {28'b0, dbus_wstrb}, 32'hF);
      check("sw_stall1", {31'b0, mem_stall}, 32'h1);
      step();
      check("sw_bub_vld",  {31'b0, valid_out}, 32'h0);
      check("sw_bub_rfwe", {31'b0, wb_rf_we},  32'h0);
      check("sw_bub_wd",   wb_wd,              32'hCAFE);
      check("sw_stall2",   {31'b0, mem_stall}, 32'h1);
      step();
      dbus_ack = 1'b1;
      #1;
      check("sw_stall3", {31'b0, mem_stall}, 32'h0);
      check("sw_req3",   {31'b0, dbus_req},  32'h1);
      step();
      dbus_ack = 1'b0;
      check("sw_vld",  {31'b0, valid_out}, 32'h1);
      check("sw_rfwe", {31'b0, wb_rf_we},  32'h0);
      check("sw_wR",   {27'b0, wb_wR},     32'd5);

      // LB, zero-wait ack on byte 3
      drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b000, 5'd7, 32'h2003, 32'h0);
      dbus_ack   = 1'b1;
      dbus_rdata = 32'h80AA55CC;
      #1;
      check("lb_stall", {31'b0, mem_stall},  32'h0);
      check("lb_req",   {31'b0, dbus_req},   32'h1);
      check("lb_addr",  dbus_addr,           32'h2000);
      check("lb_wstrb", {28'b0, dbus_wstrb}, 32'h0);
      step();
      check("lb_wd",   wb_wd,              32'hFFFFFF80);
      check("lb_rfwe", {31'b0, wb_rf_we},  32'h1);
      check("lb_vld",  {31'b0, valid_out}, 32'h1);

      // LHU upper half, LH lower half, LW
      drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b101, 5'd8, 32'h2002, 32'h0);
      step();
      check("lhu_wd", wb_wd, 32'h000080AA);
      drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b001, 5'd8, 32'h2000, 32'h0);
      step();
      check("lh_wd", wb_wd, 32'h000055CC);
      drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b100, 5'd8, 32'h2001, 32'h0);
      step();
      check("lbu_wd", wb_wd, 32'h00000055);
      drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 5'd8, 32'h2000, 32'h0);
      step();
      check("lw_wd", wb_wd, 32'h80AA55CC);

      // SB and SH lane replication
      drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 5'd0, 32'h3001, 32'h12);
      #1;
      check("sb_wdata", dbus_wdata,          32'h12121212);
      check("sb_wstrb", {28'b0, dbus_wstrb}, 32'h2);
      drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b001, 5'd0, 32'h3002, 32'hABCD1234);
      #1;
      check("sh_wdata", dbus_wdata,          32'h12341234);
      check("sh_wstrb", {28'b0, dbus_wstrb}, 32'hC);
      step();

      // Invalid instruction and a stray ack with no request
      drive(1'b0, 1'b0, 1'b1, 2'b01, 3'b010, 5'd9, 32'h4000, 32'h0);
      dbus_ack = 1'b1;
      #1 check("inv_req", {31'b0, dbus_req}, 32'h0);
      step();
      dbus_ack = 1'b0;
      check("inv_vld",  {31'b0, valid_out}, 32'h0);
      check("inv_rfwe", {31'b0, wb_rf_we},  32'h0);

      // Reset while BUSY, then a late ack
      drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 5'd10, 32'h4000, 32'h0);
      #1 check("busy_stall", {31'b0, mem_stall}, 32'h1);
      step();
      #2 cpu_rst_n = 1'b0;
      #1;
      check("rb_req",   {31'b0, dbus_req},  32'h0);
      check("rb_stall", {31'b0, mem_stall}, 32'h0);
      check("rb_wd",    wb_wd,              32'h0);
      check("rb_inst",  wb_inst,            32'h0);
      check("rb_vld",   {31'b0, valid_out}, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
      step();
      cpu_rst_n = 1'b1;
      dbus_ack  = 1'b1;
      #1 check("late_req", {31'b0, dbus_req}, 32'h0);
      step();
      dbus_ack = 1'b0;
      check("late_vld",  {31'b0, valid_out}, 32'h0);
      check("late_rfwe", {31'b0, wb_rf_we},  32'h0);
      // FSM must be back in IDLE: an ALU op causes no stall
      drive(1'b1, 1'b0, 1'b1, 2'b00, 3'b000, 5'd4, 32'h77, 32'h0);
      #1 check("post_stall", {31'b0, mem_stall}, 32'h0);
      step();
      check("post_wd", wb_wd, 32'h77);

`ifdef MEM_MISALIGN_TRAP_EN
      drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 5'd6, 32'h1002, 32'h0);
      #1;
      check("mis_req",   {31'b0, dbus_req},  32'h0);
      check("mis_stall", {31'b0, mem_stall}, 32'h0);
      step();
      check("mis_flag", {31'b0, wb_misalign}, 32'h1);
      check("mis_rfwe", {31'b0, wb_rf_we},    32'h0);
      check("mis_vld",  {31'b0, valid_out},   32'h1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
